// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
// Shared types and helpers for the memory-access stage (mem_stage_lsu) and
// its byte-lane alignment sub-module (lsu_align).
//   lsu_state_t  : access FSM states (IDLE / REQ / WAIT_R)
//   F3_*         : funct3 encodings for load/store widths
//   be_for_size  : byte-enable pattern for a given size and byte offset
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // size is funct3[1:0]: 00 byte, 01 half, anything else a full word.
    function automatic logic [3:0] be_for_size(input logic [1:0] size,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align
// Purely combinational byte-lane logic for the memory stage.
// Ports:
//   funct3     in   access width / signedness
//   addr       in   effective byte address (only [1:0] matter here)
//   store_data in   right-aligned store source
//   rdata      in   raw 32-bit word returned by data memory
//   be         out  byte enables for the access
//   wdata      out  store data replicated across all lanes
//   load_data  out  selected lane of rdata, sign/zero extended
//   misalign   out  half not on a 2-byte boundary, or word not on 4
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [1:0]  off;
    logic [31:0] rshift;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign off = addr[1:0];

    always_comb begin
        be = be_for_size(funct3[1:0], off);

        // Replicating the source lets the memory pick whichever lane be enables.
        case (funct3[1:0])
            2'b00:   wdata = {4{store_data[7:0]}};
            2'b01:   wdata = {2{store_data[15:0]}};
            default: wdata = store_data;
        endcase

        misalign = ((funct3[1:0] == 2'b01) && off[0]) ||
                   ((funct3[1:0] == 2'b10) && (off != 2'b00));

        rshift = rdata >> {off, 3'b000};
        byte_s = $signed(rshift[7:0]);
        half_s = $signed(rshift[15:0]);

        case (funct3)
            F3_LB:   load_data = 32'(byte_s);
            F3_LH:   load_data = 32'(half_s);
            F3_LBU:  load_data = {24'd0, rshift[7:0]};
            F3_LHU:  load_data = {16'd0, rshift[15:0]};
            default: load_data = rshift;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Memory-access stage: issues loads/stores over a req/gnt/rvalid handshake,
// stalls the upstream pipeline while an access is outstanding, and owns the
// MEM/WB result register (all out_* are registered).
// Optional feature: define LSU_TIMEOUT_EN to abort accesses that spend
// TIMEOUT_CYCLES cycles in REQ+WAIT_R (reported through out_err).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_*                EX/MEM register contents (held stable while stalled)
//   dmem_req/we/be/addr/wdata  request side of the data-memory port
//   dmem_gnt/rvalid/rdata      grant and response side
//   mem_stall           combinational hold for EX/MEM and upstream
//   out_valid/rd/data/misalign/err  MEM/WB result register
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_misalign,
    output logic        out_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_stage_lsu: TIMEOUT_CYCLES must be at least 2");
    end

    lsu_state_t  state_q, state_d;
    logic        is_access;
    logic        misalign;
    logic [31:0] load_data;
    logic        timeout_hit;
    logic        abort;

    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_misalign_q, out_misalign_d;
    logic        out_err_q, out_err_d;

    lsu_align u_align (
        .funct3     (in_funct3),
        .addr       (in_alu_res),
        .store_data (in_store_data),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    // The stall keeps the EX/MEM inputs stable, so address/be/wdata are
    // driven straight from them and stay constant for the life of a request.
    assign dmem_addr = {in_alu_res[31:2], 2'b00};
    assign dmem_we   = dmem_req & in_mem_write;
    assign is_access = in_valid & (in_mem_read | in_mem_write);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q != IDLE) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cleared while idle and on abort, so it never wraps past TIMEOUT-1.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == IDLE || abort) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Access FSM and result-register next values. While stalled the result
    // register holds everything except out_valid, which drops to 0 so a
    // stalled instruction is never written back twice.
    always_comb begin
        state_d        = state_q;
        dmem_req       = 1'b0;
        mem_stall      = 1'b0;
        abort          = 1'b0;
        out_valid_d    = 1'b0;
        out_rd_d       = out_rd_q;
        out_data_d     = out_data_q;
        out_misalign_d = out_misalign_q;
        out_err_d      = out_err_q;

        unique case (state_q)
            IDLE, REQ: begin
                if (state_q == IDLE && !is_access) begin
                    out_valid_d    = in_valid;
                    out_rd_d       = in_rd;
                    out_data_d     = in_alu_res;
                    out_misalign_d = 1'b0;
                    out_err_d      = 1'b0;
                end else if (state_q == IDLE && misalign) begin
                    out_valid_d    = 1'b1;
                    out_rd_d       = in_rd;
                    out_data_d     = in_alu_res;
                    out_misalign_d = 1'b1;
                    out_err_d      = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (dmem_gnt) begin
                        if (in_mem_write) begin
                            // Stores retire on the grant cycle.
                            mem_stall      = 1'b0;
                            state_d        = IDLE;
                            out_valid_d    = 1'b1;
                            out_rd_d       = in_rd;
                            out_data_d     = in_alu_res;
                            out_misalign_d = 1'b0;
                            out_err_d      = 1'b0;
                        end else begin
                            state_d = WAIT_R;
                        end
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    state_d        = IDLE;
                    out_valid_d    = 1'b1;
                    out_rd_d       = in_rd;
                    out_data_d     = load_data;
                    out_misalign_d = 1'b0;
                    out_err_d      = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d        = IDLE;
            out_valid_d    = 1'b1;
            out_rd_d       = in_rd;
            out_data_d     = '0;
            out_misalign_d = 1'b0;
            out_err_d      = 1'b1;
        end
    end

    // ---- MEM/WB boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            out_valid_q    <= 1'b0;
            out_rd_q       <= '0;
            out_data_q     <= '0;
            out_misalign_q <= 1'b0;
            out_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_rd_q       <= out_rd_d;
            out_data_q     <= out_data_d;
            out_misalign_q <= out_misalign_d;
            out_err_q      <= out_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rd       = out_rd_q;
    assign out_data     = out_data_q;
    assign out_misalign = out_misalign_q;
    assign out_err      = out_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
// Directed bench for mem_stage_lsu. Expected MEM/WB results are pushed to a
// scoreboard queue when an instruction is presented and popped when it
// retires. Build with LSU_TIMEOUT_EN defined to include the timeout step.
module tb_mem_stage_lsu;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_mem_read, in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_res, in_store_data;
    logic [4:0]  in_rd;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_misalign, out_err;

    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_funct3     (in_funct3),
        .in_alu_res    (in_alu_res),
        .in_store_data (in_store_data),
        .in_rd         (in_rd),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_be       (dmem_be),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .mem_stall     (mem_stall),
        .out_valid     (out_valid),
        .out_rd        (out_rd),
        .out_data      (out_data),
        .out_misalign  (out_misalign),
        .out_err       (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic v, input logic [4:0] rd, input logic [31:0] d,
                                input logic mis, input logic err);
        res_t r;
        r.valid = v; r.rd = rd; r.data = d; r.mis = mis; r.err = err;
        return r;
    endfunction

    // Independent reference for load extraction: select the lane by index.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        int sh;
        sh = 8 * int'(addr[1:0]);
        b  = rdata[sh +: 8];
        h  = (addr[1] == 1'b1) ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    task automatic check_out(input string name, input res_t e);
        chk({name, "_out_valid"}, 32'(out_valid), 32'(e.valid));
        chk({name, "_out_rd"}, 32'(out_rd), 32'(e.rd));
        chk({name, "_out_data"}, out_data, e.data);
        chk({name, "_out_misalign"}, 32'(out_misalign), 32'(e.mis));
        chk({name, "_out_err"}, 32'(out_err), 32'(e.err));
    endtask

    // Presents one instruction at a negedge and runs it to retirement.
    // gnt_at / rv_at are the cycle indices (from presentation) at which the
    // memory grants / returns data; -1 means never.
    task automatic do_op(input string name, input logic v, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input int gnt_at, input int rv_at,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic exp_seen,
                         input logic exp_req_done, input int exp_stalls, input res_t e);
        int   stalls;
        logic seen, done, req_done;
        res_t popped;
        stalls = 0; seen = 1'b0; done = 1'b0; req_done = 1'b0;
        in_valid = v; in_mem_read = rd_en; in_mem_write = wr_en; in_funct3 = f3;
        in_alu_res = addr; in_store_data = sd; in_rd = rd;
        exp_q.push_back(e);
        for (int n = 0; n < 40 && !done; n++) begin
            dmem_gnt    = (n == gnt_at);
            dmem_rvalid = (n == rv_at);
            dmem_rdata  = rdata;
            #1;
            if (dmem_req) begin
                seen = 1'b1;
                chk({name, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({name, "_be"}, 32'(dmem_be), 32'(exp_be));
                chk({name, "_we"}, 32'(dmem_we), 32'(wr_en));
                if (wr_en) chk({name, "_wdata"}, dmem_wdata, exp_wdata);
            end
            if (mem_stall) stalls++;
            else begin
                done = 1'b1;
                req_done = dmem_req;
            end
            @(posedge clk); #1;
            if (!done) begin
                chk({name, "_stall_valid"}, 32'(out_valid), 32'd0);
                @(negedge clk);
            end
        end
        chk({name, "_completed"}, 32'(done), 32'd1);
        chk({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        chk({name, "_req_seen"}, 32'(seen), 32'(exp_seen));
        chk({name, "_req_at_done"}, 32'(req_done), 32'(exp_req_done));
        popped = exp_q.pop_front();
        check_out(name, popped);
        @(negedge clk);
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_funct3 = 3'b000;
        in_alu_res = '0; in_store_data = '0; in_rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_out("reset", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0));
        chk("reset_stall", 32'(mem_stall), 32'd0);
        chk("reset_req", 32'(dmem_req), 32'd0);

        // Non-memory instruction with a stray rvalid that must be ignored.
        do_op("alu", 1'b1, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd7, -1, 0,
              32'hDEAD_0000, 4'b0000, 32'h0, 1'b0, 1'b0, 0,
              mk(1'b1, 5'd7, 32'h1234_5678, 1'b0, 1'b0));

        do_op("sw", 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 0, -1,
              32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b1, 0,
              mk(1'b1, 5'd1, 32'h0000_0100, 1'b0, 1'b0));

        do_op("sb", 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h1234_56AB, 5'd2, 0, -1,
              32'h0, 4'b0100, 32'hABAB_ABAB, 1'b1, 1'b1, 0,
              mk(1'b1, 5'd2, 32'h0000_0102, 1'b0, 1'b0));

        do_op("sh", 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd12, 1, -1,
              32'h0, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1'b1, 1,
              mk(1'b1, 5'd12, 32'h0000_0202, 1'b0, 1'b0));

        do_op("lb", 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd3, 0, 1,
              32'h8000_0000, 4'b1000, 32'h0, 1'b1, 1'b0, 1,
              mk(1'b1, 5'd3, ref_load(3'b000, 32'h103, 32'h8000_0000), 1'b0, 1'b0));

        do_op("lbu", 1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd4, 0, 1,
              32'h8000_0000, 4'b1000, 32'h0, 1'b1, 1'b0, 1,
              mk(1'b1, 5'd4, 32'h0000_0080, 1'b0, 1'b0));

        do_op("lh_wait", 1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd5, 3, 5,
              32'h8001_1234, 4'b1100, 32'h0, 1'b1, 1'b0, 5,
              mk(1'b1, 5'd5, ref_load(3'b001, 32'h102, 32'h8001_1234), 1'b0, 1'b0));

        do_op("lhu", 1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd6, 0, 1,
              32'h8001_1234, 4'b1100, 32'h0, 1'b1, 1'b0, 1,
              mk(1'b1, 5'd6, 32'h0000_8001, 1'b0, 1'b0));

        do_op("lw", 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd8, 1, 3,
              32'hCAFE_F00D, 4'b1111, 32'h0, 1'b1, 1'b0, 3,
              mk(1'b1, 5'd8, 32'hCAFE_F00D, 1'b0, 1'b0));

        do_op("sh_mis", 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0000_5555, 5'd9, 0, -1,
              32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 0,
              mk(1'b1, 5'd9, 32'h0000_0101, 1'b1, 1'b0));

        do_op("lw_mis", 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd10, 0, 1,
              32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 1'b0, 0,
              mk(1'b1, 5'd10, 32'h0000_0102, 1'b1, 1'b0));

        // Reset while a load waits for data, then a stray response.
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'b010;
        in_alu_res = 32'h0000_0200; in_rd = 5'd11;
        dmem_gnt = 1'b1;
        #1;
        chk("rst_wr_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        chk("rst_wr_stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0; in_mem_read = 1'b0; in_alu_res = '0; in_rd = '0;
        @(posedge clk); #1;
        check_out("rst_wr", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0));
        chk("rst_wr_req_drop", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("stray_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check_out("stray", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0));
        @(negedge clk);
        dmem_rvalid = 1'b0;

        // A store with immediate grant retires without stall only from IDLE.
        do_op("sw_after_rst", 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0BAD_F00D, 5'd13, 0, -1,
              32'h0, 4'b1111, 32'h0BAD_F00D, 1'b1, 1'b1, 0,
              mk(1'b1, 5'd13, 32'h0000_0300, 1'b0, 1'b0));

`ifdef LSU_TIMEOUT_EN
        do_op("timeout", 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd14, -1, -1,
              32'h1111_1111, 4'b1111, 32'h0, 1'b1, 1'b0, 4,
              mk(1'b1, 5'd14, 32'h0, 1'b0, 1'b1));
`endif

        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
